mem_lsu_ctrl: RTL and testbench
===============================

Name: mem_lsu_ctrl

Overview:
- Load/store initiator that drives the word-addressed data RAM port: write enable, byte address, write data, with asynchronous read data back.
- Converts core-side byte/half/word load and store requests into RAM accesses.
- Sub-word stores are done as a read-modify-write.
- Returns sign/zero-extended load data and flags misaligned or out-of-range requests.
- Sits between the core's MEM stage and the data RAM.

Parameters:
- ADDR_LEN, 16: RAM word-address width. The RAM holds 2^ADDR_LEN words and is indexed by byte-address bits [ADDR_LEN+1:2].

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as an error
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (low bits used)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request was misaligned, out-of-range, or had size 11
- ram_we  out  1  RAM write enable
- ram_addr  out  32  RAM byte address; word-aligned (bits [1:0] = 0)
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, combinational from ram_addr

Behaviour:
- Reset: on a posedge with rst_n = 0, the block enters IDLE and clears all outputs: resp_valid = 0, resp_rdata = 0, resp_err = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
  - ram_we is also gated combinationally by rst_n, so no RAM write occurs in a cycle where rst_n = 0, even mid-operation.
  - An in-flight request is dropped with no response.
- States are IDLE, RD, WR and RESP.
- IDLE:
  - req_ready = 1, ram_we = 0, ram_addr = 0.
  - On req_valid & req_ready, latch we, size, unsigned, addr and wdata.
  - An error exists if any of these hold: size = 11; size = 01 with addr[0] = 1; size = 10 with addr[1:0] != 0; any addr bit [31:ADDR_LEN+2] set.
  - If there is an error, go to RESP with resp_err = 1 and resp_rdata = 0. No RAM access is made.
  - Otherwise, a load or a byte/half store goes to RD. A word store goes to WR with merge buffer = wdata.
- RD:
  - ram_addr = {latched addr[31:2], 2'b00}, ram_we = 0.
  - For a load, select the byte/half at addr[1:0] (little-endian), extend it to 32 bits per req_unsigned, register it into resp_rdata, and go to RESP.
  - For a sub-word store, build the merge buffer from ram_rdata with the target byte/half lanes replaced by the low bits of wdata, and go to WR.
- WR:
  - ram_we = 1, ram_addr = aligned addr, ram_wdata = merge buffer. The RAM commits at the closing posedge.
  - Next state is RESP with resp_rdata = 0 and resp_err = 0.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable while resp_ready = 0.
  - On resp_ready, go to IDLE and drop resp_valid the next cycle.
  - No new request is accepted until IDLE, so req_ready = 0 in RD, WR and RESP.
- Latency in cycles after the accept edge, with resp_ready held high:
  - error: resp_valid after 1
  - load: after 2
  - word store: after 2
  - byte/half store: after 3
  - Throughput is at most one request per (latency + 1) cycles.
- A word or word-read word-write is never split across words; an access that crosses a word boundary is an error by definition.
- Only bytes outside the target lanes must be preserved by a store; the merge uses the RAM word read in RD.

Test Plan:
- Reset then preload RAM word 0x4 = 0x8899AABB. Load byte at 0x6, signed -> resp_rdata = 0xFFFFFF99, err = 0, resp_valid exactly 2 cycles after accept. Same load unsigned -> 0x00000099.
- Store half 0x1234 to 0x6 with word 0x4 = 0x8899AABB -> exactly one ram_we pulse (in WR, 2 cycles after accept). Word 0x4 becomes 0x1234AABB, and a later load word at 0x4 returns 0x1234AABB.
- Word store 0xDEADBEEF at 0x10 -> ram_we one cycle after accept with ram_addr = 0x10. resp_valid at +2 with resp_rdata = 0.
- Errors -> resp_err = 1 at +1 and ram_we never asserted:
  - load word at 0x2
  - store half at 0x3
  - size = 11
  - addr = 0x00040000 with ADDR_LEN = 16
- Backpressure: hold resp_ready = 0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready = 0 throughout. When released, req_ready = 1 on the next cycle.
- Reset mid-operation: assert rst_n = 0 during WR of a byte store -> no RAM write, RAM word unchanged, resp_valid = 0 and the block back in IDLE on the next cycle.

Source files
------------

// File: rtl/mem_lsu_ctrl_if.sv
// Core/RAM bus bundle for the load/store unit.
// slave = the LSU itself; master = the core plus the data RAM around it.
interface mem_lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_lsu_ctrl.sv
// Load/store initiator: turns byte/half/word core requests into accesses on a
// word-wide data RAM with combinational read data. Sub-word stores use a
// read-modify-write through a merge buffer.
module mem_lsu_ctrl #(
  parameter int ADDR_LEN = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_we, r_uns, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_merge, r_rdata;

  logic        w_err, w_oor;
  logic [31:0] w_aligned, w_shifted, w_load, w_mask, w_merge;
  logic [4:0]  w_sh;

  assign w_aligned = {r_addr[31:2], 2'b00};
  assign w_sh      = {r_addr[1:0], 3'b000};
  assign w_shifted = bus.ram_rdata >> w_sh;
  // Any address bit above the RAM's byte range makes the request out of range.
  assign w_oor     = |(bus.req_addr >> (ADDR_LEN + 2));

  // Request validity: size 11, misalignment or out-of-range address.
  always_comb begin
    w_err = w_oor;
    case (bus.req_size)
      2'b00:   w_err = w_oor;
      2'b01:   w_err = w_oor | bus.req_addr[0];
      2'b10:   w_err = w_oor | (|bus.req_addr[1:0]);
      default: w_err = 1'b1;
    endcase
  end

  // Load lane select/extension and sub-word store merge from the RAM word.
  always_comb begin
    case (r_size)
      2'b00:   w_load = r_uns ? {24'b0, w_shifted[7:0]}
                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = r_uns ? {16'b0, w_shifted[15:0]}
                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = bus.ram_rdata;
    endcase
    w_mask  = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
    w_merge = (bus.ram_rdata & ~w_mask) | ((r_wdata << w_sh) & w_mask);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and bus outputs; ram_we is gated by reset so no write can
  // slip through while rst_n is low.
  always_comb begin
    w_next         = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.ram_we     = 1'b0;
    bus.ram_addr   = 32'b0;
    bus.ram_wdata  = 32'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (w_err)                                   w_next = S_RESP;
          else if (bus.req_we && bus.req_size == 2'b10) w_next = S_WR;
          else                                         w_next = S_RD;
        end
      end
      S_RD: begin
        bus.ram_addr = w_aligned;
        w_next       = r_we ? S_WR : S_RESP;
      end
      S_WR: begin
        bus.ram_we    = rst_n;
        bus.ram_addr  = w_aligned;
        bus.ram_wdata = r_merge;
        w_next        = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  // Request latch, merge buffer and response data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 32'b0;
      r_wdata <= 32'b0;
      r_merge <= 32'b0;
      r_rdata <= 32'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_we    <= bus.req_we;
          r_uns   <= bus.req_unsigned;
          r_size  <= bus.req_size;
          r_addr  <= bus.req_addr;
          r_wdata <= bus.req_wdata;
          r_merge <= bus.req_wdata;
          r_rdata <= 32'b0;
          r_err   <= w_err;
        end
        S_RD: begin
          if (r_we) r_merge <= w_merge;
          else      r_rdata <= w_load;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed bench for mem_lsu_ctrl with a small behavioural RAM.
module tb_mem_lsu_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_lsu_ctrl_if bus ();

  mem_lsu_ctrl #(.ADDR_LEN(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // RAM model: 256 words, combinational read, write at posedge.
  logic [31:0] mem [0:255];
  logic        bk_we = 1'b0;
  logic [7:0]  bk_idx = 8'd0;
  logic [31:0] bk_data = 32'd0;
  int          we_cnt = 0;

  assign bus.ram_rdata = mem[bus.ram_addr[9:2]];

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
    if (bk_we)      mem[bk_idx] <= bk_data;
  end

  always @(posedge clk) if (bus.ram_we) we_cnt++;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    bk_we = 1'b1; bk_idx = idx; bk_data = d;
    @(posedge clk); #1;
    bk_we = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one request; return latency to resp_valid, first ram_we cycle/addr
  // and the response fields seen when resp_valid rises.
  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output int we_at, output logic [31:0] we_addr,
                      output logic [31:0] rd, output logic er);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; we_at = 0; we_addr = 32'b0;
    while (!bus.resp_valid && lat < 20) begin
      if (bus.ram_we && we_at == 0) begin we_at = lat; we_addr = bus.ram_addr; end
      step();
      lat++;
    end
    if (!bus.resp_valid) chk("resp_timeout", {31'b0, bus.resp_valid}, 32'd1);
    rd = bus.resp_rdata;
    er = bus.resp_err;
  endtask

  int          lat, we_at, wc;
  logic [31:0] we_addr, rd, held;
  logic        er;

  logic [1:0]  e_sz   [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
  logic        e_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] e_addr [4] = '{32'h2, 32'h3, 32'h8, 32'h0004_0000};

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'b0; bus.req_wdata = 32'b0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
    chk("rst_ram_we",     {31'b0, bus.ram_we},     32'd0);
    chk("rst_ram_addr",   bus.ram_addr,  32'd0);
    chk("rst_ram_wdata",  bus.ram_wdata, 32'd0);
    rst_n = 1'b1;

    poke(8'd1,   32'h8899_AABB);
    poke(8'd255, 32'hCAFE_F00D);

    // Loads from word 0x4.
    send(1'b0, 2'b00, 1'b0, 32'h6, 32'h0, lat, we_at, we_addr, rd, er);
    chk("lb_s_lat", lat, 2); chk("lb_s_data", rd, 32'hFFFF_FF99); chk("lb_s_err", {31'b0, er}, 0);
    step();
    send(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, lat, we_at, we_addr, rd, er);
    chk("lb_u_data", rd, 32'h0000_0099);
    step();

    // Half store: read-modify-write.
    wc = we_cnt;
    send(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234, lat, we_at, we_addr, rd, er);
    chk("sh_lat", lat, 3); chk("sh_we_at", we_at, 2); chk("sh_we_addr", we_addr, 32'h4);
    chk("sh_rdata", rd, 32'h0);
    step();
    chk("sh_we_pulses", we_cnt - wc, 1);
    chk("sh_mem", mem[1], 32'h1234_AABB);
    send(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, we_at, we_addr, rd, er);
    chk("lw_data", rd, 32'h1234_AABB);
    step();
    send(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, lat, we_at, we_addr, rd, er);
    chk("lh_s_data", rd, 32'hFFFF_AABB);
    step();
    send(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, lat, we_at, we_addr, rd, er);
    chk("lh_u_data", rd, 32'h0000_1234);
    step();

    // Word store, then a byte store merged into it.
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, we_at, we_addr, rd, er);
    chk("sw_lat", lat, 2); chk("sw_we_at", we_at, 1); chk("sw_we_addr", we_addr, 32'h10);
    chk("sw_rdata", rd, 32'h0);
    step();
    chk("sw_mem", mem[4], 32'hDEAD_BEEF);
    send(1'b1, 2'b00, 1'b0, 32'h11, 32'hABCD_EFFF, lat, we_at, we_addr, rd, er);
    chk("sb_lat", lat, 3);
    step();
    chk("sb_mem", mem[4], 32'hDEAD_FFEF);

    // Highest in-range word.
    send(1'b0, 2'b10, 1'b0, 32'h0003_FFFC, 32'h0, lat, we_at, we_addr, rd, er);
    chk("top_err", {31'b0, er}, 0); chk("top_data", rd, 32'hCAFE_F00D);
    step();

    // Error requests: response after one cycle, no RAM write.
    for (int i = 0; i < 4; i++) begin
      wc = we_cnt;
      send(e_we[i], e_sz[i], 1'b0, e_addr[i], 32'hFFFF_FFFF, lat, we_at, we_addr, rd, er);
      chk($sformatf("err%0d_lat", i), lat, 1);
      chk($sformatf("err%0d_flag", i), {31'b0, er}, 1);
      chk($sformatf("err%0d_rdata", i), rd, 0);
      step();
      chk($sformatf("err%0d_nowe", i), we_cnt - wc, 0);
    end

    // Backpressure on a load response.
    bus.resp_ready = 1'b0;
    send(1'b0, 2'b00, 1'b0, 32'h4, 32'h0, lat, we_at, we_addr, rd, er);
    chk("bp_data", rd, 32'hFFFF_FFBB);
    held = rd;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {31'b0, bus.resp_valid}, 1);
      chk("bp_rdata", bus.resp_rdata, held);
      chk("bp_req_ready", {31'b0, bus.req_ready}, 0);
    end
    bus.resp_ready = 1'b1;
    step();
    chk("bp_rel_ready", {31'b0, bus.req_ready}, 1);
    chk("bp_rel_valid", {31'b0, bus.resp_valid}, 0);

    // Reset asserted during WR of a byte store.
    wc = we_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_addr = 32'h5; bus.req_wdata = 32'h55;
    step();
    bus.req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we_gated", {31'b0, bus.ram_we}, 0);
    step();
    chk("mid_rst_valid", {31'b0, bus.resp_valid}, 0);
    chk("mid_rst_idle", {31'b0, bus.req_ready}, 1);
    chk("mid_rst_mem", mem[1], 32'h1234_AABB);
    chk("mid_rst_nowe", we_cnt - wc, 0);
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
